// File: rtl/tilemap_arbiter.sv
// Shares one synchronous-read tile RAM between the VGA fetch path (priority) and game logic.
// Optional range checking with game_err output is enabled by defining TILEMAP_BOUNDS_EN.
module tilemap_arbiter #(
    parameter int ROWS       = 12,
    parameter int COLS       = 17,
    parameter int TW         = 8,
    parameter int STARVE_MAX = 64,
    parameter int AW         = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [3:0]    vid_row,
    input  logic [4:0]    vid_col,
    output logic          vid_valid,
    output logic [TW-1:0] vid_tile,
    output logic          vid_miss,
    input  logic          game_req,
    input  logic          game_we,
    input  logic [3:0]    game_row,
    input  logic [4:0]    game_col,
    input  logic [TW-1:0] game_wdata,
    output logic          game_ack,
    output logic [TW-1:0] game_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [TW-1:0] ram_wdata,
`ifdef TILEMAP_BOUNDS_EN
    output logic          game_err,
`endif
    input  logic [TW-1:0] ram_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_GAME} owner_t;
    typedef enum logic [1:0] {G_IDLE, G_ISSUED, G_DONE} gstate_t;

    generate
        if ((2 ** AW) < (ROWS * COLS)) begin : g_aw_check
            $error("tilemap_arbiter: AW too small for ROWS*COLS");
        end
    endgenerate

    gstate_t       gstate, gstate_nx;
    logic [SW-1:0] starve_cnt, starve_nx;
    logic          vid_win, game_win, vid_drop;
    logic          vid_oob, game_oob;
    logic [AW-1:0] vid_addr, game_addr;

    owner_t s1_owner, s2_owner;
    logic   s1_miss, s2_miss;
    logic   s1_we, s2_we;
    logic   s1_oob, s2_oob;

    function automatic logic [AW-1:0] tile_addr(input logic [3:0] row, input logic [4:0] col);
        logic [AW-1:0] r, c;
        r = AW'(row);
        c = AW'(col);
        return r * AW'(COLS) + c;
    endfunction

    assign vid_addr  = tile_addr(vid_row, vid_col);
    assign game_addr = tile_addr(game_row, game_col);

`ifdef TILEMAP_BOUNDS_EN
    assign vid_oob  = (32'(vid_row) >= ROWS) || (32'(vid_col) >= COLS);
    assign game_oob = (32'(game_row) >= ROWS) || (32'(game_col) >= COLS);
`else
    assign vid_oob  = 1'b0;
    assign game_oob = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            gstate     <= G_IDLE;
            starve_cnt <= '0;
        end else begin
            gstate     <= gstate_nx;
            starve_cnt <= starve_nx;
        end
    end

    // A saturated starvation counter lets a pending game op steal the slot from video.
    always_comb begin
        vid_win   = 1'b0;
        game_win  = 1'b0;
        vid_drop  = 1'b0;
        starve_nx = starve_cnt;
        gstate_nx = gstate;

        if (starve_cnt == SW'(STARVE_MAX) && gstate == G_IDLE && game_req) begin
            game_win = 1'b1;
            vid_drop = vid_req;
        end else if (vid_req) begin
            vid_win = 1'b1;
        end else if (game_req && gstate == G_IDLE) begin
            game_win = 1'b1;
        end

        if (!game_req || game_win) begin
            starve_nx = '0;
        end else if (gstate == G_IDLE && starve_cnt != SW'(STARVE_MAX)) begin
            starve_nx = starve_cnt + SW'(1);
        end

        case (gstate)
            G_IDLE:   if (game_win) gstate_nx = G_ISSUED;
            G_ISSUED: if (s2_owner == OWN_GAME) gstate_nx = G_DONE;
            G_DONE:   gstate_nx = G_IDLE;
            default:  gstate_nx = G_IDLE;
        endcase
    end

    // Issue stage: idle and out-of-range slots leave ram_addr untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            s1_owner  <= OWN_NONE;
            s1_miss   <= 1'b0;
            s1_we     <= 1'b0;
            s1_oob    <= 1'b0;
        end else begin
            ram_we   <= 1'b0;
            s1_owner <= OWN_NONE;
            s1_miss  <= vid_drop;
            s1_we    <= 1'b0;
            s1_oob   <= 1'b0;
            if (vid_win) begin
                s1_owner <= OWN_VID;
                s1_oob   <= vid_oob;
                if (!vid_oob) ram_addr <= vid_addr;
            end else if (game_win) begin
                s1_owner <= OWN_GAME;
                s1_we    <= game_we;
                s1_oob   <= game_oob;
                if (!game_oob) begin
                    ram_addr <= game_addr;
                    ram_we   <= game_we;
                    if (game_we) ram_wdata <= game_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_owner <= OWN_NONE;
            s2_miss  <= 1'b0;
            s2_we    <= 1'b0;
            s2_oob   <= 1'b0;
        end else begin
            s2_owner <= s1_owner;
            s2_miss  <= s1_miss;
            s2_we    <= s1_we;
            s2_oob   <= s1_oob;
        end
    end

    // ram_rdata belongs to the S2 slot; capture it for whichever owner the tag names.
    always_ff @(posedge clk) begin
        if (reset) begin
            vid_valid  <= 1'b0;
            vid_miss   <= 1'b0;
            vid_tile   <= '0;
            game_ack   <= 1'b0;
            game_rdata <= '0;
`ifdef TILEMAP_BOUNDS_EN
            game_err   <= 1'b0;
`endif
        end else begin
            vid_valid <= (s2_owner == OWN_VID);
            vid_miss  <= s2_miss;
            game_ack  <= (s2_owner == OWN_GAME);
`ifdef TILEMAP_BOUNDS_EN
            game_err  <= (s2_owner == OWN_GAME) && s2_oob;
`endif
            if (s2_owner == OWN_VID) vid_tile <= s2_oob ? '0 : ram_rdata;
            if (s2_owner == OWN_GAME) game_rdata <= (s2_we || s2_oob) ? '0 : ram_rdata;
        end
    end

endmodule

// File: tb/tb_tilemap_arbiter.sv
// Scoreboard bench for tilemap_arbiter: directed vectors push expectations, a negedge monitor pops them.
module tb_tilemap_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       vid_req;
    logic [3:0] vid_row;
    logic [4:0] vid_col;
    logic       vid_valid;
    logic [7:0] vid_tile;
    logic       vid_miss;
    logic       game_req;
    logic       game_we;
    logic [3:0] game_row;
    logic [4:0] game_col;
    logic [7:0] game_wdata;
    logic       game_ack;
    logic [7:0] game_rdata;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
`ifdef TILEMAP_BOUNDS_EN
    logic       game_err;
`endif

    tilemap_arbiter dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_row(vid_row), .vid_col(vid_col),
        .vid_valid(vid_valid), .vid_tile(vid_tile), .vid_miss(vid_miss),
        .game_req(game_req), .game_we(game_we), .game_row(game_row), .game_col(game_col),
        .game_wdata(game_wdata), .game_ack(game_ack), .game_rdata(game_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
`ifdef TILEMAP_BOUNDS_EN
        .game_err(game_err),
`endif
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Tile RAM model: synchronous read returning old data, with a one-shot preload.
    logic       load_en;
    logic [7:0] mem [0:255];

    function automatic logic [7:0] preload(input int a);
        case (a)
            17:      return 8'hA5;
            20:      return 8'h03;
            33:      return 8'h44;
            39:      return 8'h5C;
            203:     return 8'hCB;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= preload(i);
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    typedef struct {
        int         cyc;
        logic       miss;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t vidq[$];
    exp_t gameq[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pushVid(input logic [7:0] tile, input int at);
        exp_t e;
        e.cyc = at; e.miss = 1'b0; e.data = tile; e.err = 1'b0;
        vidq.push_back(e);
    endtask

    task automatic pushMiss(input int at);
        exp_t e;
        e.cyc = at; e.miss = 1'b1; e.data = 8'h00; e.err = 1'b0;
        vidq.push_back(e);
    endtask

    task automatic pushGame(input logic [7:0] rdata, input logic err, input int at);
        exp_t e;
        e.cyc = at; e.miss = 1'b0; e.data = rdata; e.err = err;
        gameq.push_back(e);
    endtask

    task automatic applyStimulus(input logic vr, input logic [3:0] vrow, input logic [4:0] vcol,
                                 input logic gr, input logic gwe, input logic [3:0] grow,
                                 input logic [4:0] gcol, input logic [7:0] gwd);
        @(posedge clk);
        #1;
        vid_req = vr; vid_row = vrow; vid_col = vcol;
        game_req = gr; game_we = gwe; game_row = grow; game_col = gcol; game_wdata = gwd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_vid_valid"}, 32'(vid_valid), 0);
        checkOutput({tag, "_vid_miss"}, 32'(vid_miss), 0);
        checkOutput({tag, "_game_ack"}, 32'(game_ack), 0);
        checkOutput({tag, "_ram_we"}, 32'(ram_we), 0);
        checkOutput({tag, "_vid_tile"}, 32'(vid_tile), 0);
        checkOutput({tag, "_game_rdata"}, 32'(game_rdata), 0);
        checkOutput({tag, "_ram_addr"}, 32'(ram_addr), 0);
        checkOutput({tag, "_ram_wdata"}, 32'(ram_wdata), 0);
    endtask

    // Monitor: every output event must match the head of its queue, including its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0) begin
            if (vid_valid || vid_miss) begin
                if (vidq.size() == 0) begin
                    checkOutput("vid_unexpected", {30'd0, vid_valid, vid_miss}, 0);
                end else begin
                    e = vidq.pop_front();
                    checkOutput("vid_cycle", cyc, e.cyc);
                    checkOutput("vid_valid", 32'(vid_valid), 32'(!e.miss));
                    checkOutput("vid_miss", 32'(vid_miss), 32'(e.miss));
                    if (!e.miss) checkOutput("vid_tile", 32'(vid_tile), 32'(e.data));
                end
            end
            if (game_ack) begin
                if (gameq.size() == 0) begin
                    checkOutput("game_ack_unexpected", 32'(game_ack), 0);
                end else begin
                    e = gameq.pop_front();
                    checkOutput("game_ack_cycle", cyc, e.cyc);
                    checkOutput("game_rdata", 32'(game_rdata), 32'(e.data));
`ifdef TILEMAP_BOUNDS_EN
                    checkOutput("game_err", 32'(game_err), 32'(e.err));
`endif
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k, s, g, r;
        reset = 1'b1; load_en = 1'b1;
        vid_req = 0; vid_row = 0; vid_col = 0;
        game_req = 0; game_we = 0; game_row = 0; game_col = 0; game_wdata = 0;
        repeat (3) @(posedge clk);
        #1 load_en = 1'b0;
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] video read (1,3) -> addr 20");
        applyStimulus(1, 1, 3, 0, 0, 0, 0, 0);
        k = cyc; pushVid(8'h03, k + 3);
        idle(1);
        @(negedge clk);
        checkOutput("s1_ram_addr", 32'(ram_addr), 20);
        checkOutput("s1_ram_we", 32'(ram_we), 0);
        idle(3);

        $display("[TB] game write 2 at (4,8), then video reads");
        applyStimulus(0, 0, 0, 1, 1, 4, 8, 8'h02);
        k = cyc; pushGame(8'h00, 0, k + 3);
        applyStimulus(0, 0, 0, 1, 1, 4, 8, 8'h02);
        @(negedge clk);
        checkOutput("wr_ram_addr", 32'(ram_addr), 76);
        checkOutput("wr_ram_we", 32'(ram_we), 1);
        checkOutput("wr_ram_wdata", 32'(ram_wdata), 8'h02);
        applyStimulus(0, 0, 0, 1, 1, 4, 8, 8'h02);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 4, 8, 0, 0, 0, 0, 0);
        pushVid(8'h02, cyc + 3);
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 8'h77);
        k = cyc; pushGame(8'h00, 0, k + 3);
        applyStimulus(1, 0, 0, 1, 1, 0, 0, 8'h77);
        pushVid(8'h77, cyc + 3);
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 8'h77);
        idle(5);

        $display("[TB] starvation: video every cycle, game read (2,5)");
        s = 0;
        for (int j = 0; j < 68; j++) begin
            applyStimulus(1, 1, 16, 1, 0, 2, 5, 0);
            if (j == 0) s = cyc;
            if (j == 64) begin
                pushMiss(s + 67);
                pushGame(8'h5C, 0, s + 67);
                @(negedge clk);
                checkOutput("starve_cnt_sat", 32'(dut.starve_cnt), 64);
            end else begin
                pushVid(8'h44, cyc + 3);
            end
            if (j == 66) begin
                @(negedge clk);
                checkOutput("starve_cnt_clear", 32'(dut.starve_cnt), 0);
            end
        end
        idle(5);

        $display("[TB] game read (11,16) in a gap, then continuous video");
        applyStimulus(0, 0, 0, 1, 0, 11, 16, 0);
        g = cyc; pushGame(8'hCB, 0, g + 3);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1, 1, 3, (i <= 3), 0, 11, 16, 0);
            pushVid(8'h03, cyc + 3);
            if (i == 1) begin
                @(negedge clk);
                checkOutput("gap_ram_addr", 32'(ram_addr), 203);
            end
        end
        idle(5);

        $display("[TB] reset one cycle after a game grant");
        applyStimulus(0, 0, 0, 1, 1, 3, 3, 8'h99);
        r = cyc;
        applyStimulus(1, 1, 3, 1, 1, 3, 3, 8'h99);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_cycle", cyc, r + 2);
        checkAllZero("midreset");
        applyStimulus(0, 0, 0, 1, 0, 4, 8, 0);
        k = cyc; pushGame(8'h02, 0, k + 3);
        applyStimulus(0, 0, 0, 1, 0, 4, 8, 0);
        applyStimulus(0, 0, 0, 1, 0, 4, 8, 0);
        idle(5);

`ifdef TILEMAP_BOUNDS_EN
        $display("[TB] out-of-range video (12,0) and game write (0,17)");
        applyStimulus(1, 12, 0, 0, 0, 0, 0, 0);
        k = cyc; pushVid(8'h00, k + 3);
        applyStimulus(0, 0, 0, 1, 1, 0, 17, 8'h55);
        pushGame(8'h00, 1, k + 4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, (i < 3), 1, 0, 17, 8'h55);
            @(negedge clk);
            checkOutput("oob_ram_we", 32'(ram_we), 0);
        end
`else
        $display("[TB] unchecked video (0,17) aliases to addr 17");
        applyStimulus(1, 0, 17, 0, 0, 0, 0, 0);
        k = cyc; pushVid(8'hA5, k + 3);
        idle(1);
        @(negedge clk);
        checkOutput("alias_ram_addr", 32'(ram_addr), 17);
`endif
        idle(6);

        checkOutput("vidq_left", vidq.size(), 0);
        checkOutput("gameq_left", gameq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
